frac_stim_gen: RTL and testbench
================================

Name: frac_stim_gen

Overview:
- Programmable stimulus source for the fractional-counter TDC path: drives the modulation square wave (mod) and the measured pulse train (signal) with a programmable period and phase.
- Reports, at every mod edge, the fractional count a correct receiver must capture there.
- Used as the on-chip self-test / calibration transmitter in front of the fractional counter, and as the reference model on the bench.

Parameters:
- W, 16, width of all count/config fields and of expected_frac.
- DEF_MOD_HALF, 100, reset value of the mod half-period in clk cycles.
- DEF_SIG_PERIOD, 37, reset value of the signal period in clk cycles.
- DEF_SIG_PHASE, 0, reset value of the first-signal-rise delay after a mod rise.
- DEF_PULSE_LEN, 4, reset value of the signal high time in clk cycles.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  count enable; low freezes all counters and holds outputs.
- start  in  1  pulse; IDLE->RUN.
- stop  in  1  pulse; RUN->DRAIN.
- cfg_wr  in  1  load shadow config from the cfg_* inputs.
- cfg_mod_half  in  W  mod half-period; must be >=1.
- cfg_sig_period  in  W  signal period; must be >=2.
- cfg_sig_phase  in  W  delay from mod rise to first signal rise; must be < period.
- cfg_pulse_len  in  W  signal high cycles; clamped to period-1.
- mod  out  1  modulation output, registered.
- signal  out  1  pulse output, registered.
- expected_frac  out  W  clk cycles since the last signal rise, at a mod edge.
- exp_valid  out  1  one-cycle strobe qualifying expected_frac.
- busy  out  1  high in RUN and DRAIN.
- cfg_err  out  1  one-cycle strobe: cfg_wr rejected.

Behaviour:
- Reset (async, rst_n=0):
  - mod, signal, exp_valid, cfg_err, busy = 0; expected_frac = 0; state = IDLE.
  - Shadow and active config = DEF_* parameters; all counters = 0.
- Config:
  - cfg_wr with mod_half==0, period<2 or phase>=period: cfg_err high the next cycle; shadow unchanged.
  - Otherwise shadow <= inputs, with pulse_len clamped to min(pulse_len, period-1); pending flag set.
  - In IDLE the shadow is copied to active immediately. In RUN it is copied at the next cycle where mod goes 0->1.
  - cfg_wr in the same cycle as a copy: the copy uses the old shadow; the new value stays pending.
- States:
  - IDLE: mod=signal=0. start -> RUN. start is ignored outside IDLE.
  - RUN: stop -> DRAIN.
  - DRAIN: counters keep running until the cycle mod would go 0->1. mod is held 0 instead, signal is forced 0, no exp_valid, state -> IDLE.
  - start and stop together in IDLE: start wins, and stop is ignored that cycle.
- Entering RUN (first RUN cycle = cycle 0):
  - mod=1, mod_cnt=0.
  - sig_cnt seeded to (period-phase) mod period.
  - A blank flag is set if the seed is nonzero.
- mod counter:
  - mod_cnt increments each enabled cycle.
  - When mod_cnt==mod_half-1: mod_cnt <= 0 and mod toggles.
  - mod period = 2*mod_half cycles.
- sig counter:
  - sig_cnt increments mod period, wrapping period-1 -> 0.
  - A signal rise is defined as a cycle with sig_cnt==0; this clears blank.
  - signal = (sig_cnt < pulse_len) and not blank.
  - The clamp guarantees at least one low cycle per period, so every rise is a true 0->1 edge.
- Re-seed on a pending-config copy at a mod rise:
  - Active config is replaced; sig_cnt is re-seeded as on entry to RUN, and blank is set again if the seed is nonzero.
  - The new config's phase relation holds from that edge.
- Expected value:
  - In every cycle where mod changes value (RUN only): expected_frac <= sig_cnt and exp_valid <= 1, both one cycle later.
  - Suppressed (exp_valid=0, expected_frac unchanged) while blank is set.
  - A signal rise in the same cycle as a mod edge gives 0.
- clk_en=0:
  - No counter, state or output changes; pending strobes are held off.
  - start, stop and cfg_wr are still accepted, and take effect on the next enabled cycle.
- Widths: all counters are W bits; no overflow is possible given the config limits.
- Reset mid-run: immediate return to the reset state; pending config is discarded.

Test Plan:
- cfg half=10, period=7, phase=3, len=2, then start:
  - mod rises at cycles 0, 20, 40 and falls at 10, 30; signal rises at 3, 10, 17, 24, 31 and is high 2 cycles each.
  - exp_valid one cycle after each edge: no strobe for cycle 0; values 0 (c10), 3 (c20), 6 (c30).
- phase=0, same other settings: signal and mod both rise at cycle 0 -> expected_frac=0, valid.
- cfg_wr with period=0 -> cfg_err 1 cycle, config unchanged. cfg_wr with period=7, len=9 -> signal high 6 cycles, low 1.
- Run as in the first scenario, clk_en low for cycles 12-16: mod fall moves from cycle 30 to 35, and the expected values are unchanged (0, 3, 6).
- stop at cycle 12 (first scenario):
  - busy falls at the would-be rise (cycle 20); mod and signal stay 0.
  - No strobe for cycle 20; a later start restarts at phase.
- cfg_wr period=5 at cycle 5 during a run: new period takes effect at the cycle-20 mod rise with signal re-phased.
- rst_n low at cycle 15: all outputs 0 asynchronously, defaults restored.

Source files
------------

// File: rtl/frac_stim_gen.sv
// frac_stim_gen: programmable mod/signal stimulus source reporting the fractional count expected at each mod edge
module frac_stim_gen #(
  parameter int W              = 16,
  parameter int DEF_MOD_HALF   = 100,
  parameter int DEF_SIG_PERIOD = 37,
  parameter int DEF_SIG_PHASE  = 0,
  parameter int DEF_PULSE_LEN  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_wr,
  input  logic [W-1:0] cfg_mod_half,
  input  logic [W-1:0] cfg_sig_period,
  input  logic [W-1:0] cfg_sig_phase,
  input  logic [W-1:0] cfg_pulse_len,
  output logic         mod,
  output logic         signal,
  output logic [W-1:0] expected_frac,
  output logic         exp_valid,
  output logic         busy,
  output logic         cfg_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         mod_q, mod_d, signal_q, signal_d, busy_q, busy_d;
  logic         exp_valid_q, exp_valid_d, cfg_err_q, cfg_err_d;
  logic         edge_q, edge_d, blank_q, blank_d, pend_q, pend_d;
  logic         start_p_q, start_p_d, stop_p_q, stop_p_d, err_p_q, err_p_d;
  logic [W-1:0] mod_cnt_q, mod_cnt_d, sig_cnt_q, sig_cnt_d, expected_frac_q, expected_frac_d;
  logic [W-1:0] sh_half_q, sh_half_d, sh_per_q, sh_per_d, sh_ph_q, sh_ph_d, sh_len_q, sh_len_d;
  logic [W-1:0] ac_half_q, ac_half_d, ac_per_q, ac_per_d, ac_ph_q, ac_ph_d, ac_len_q, ac_len_d;
  logic         bad, ok, start_req, stop_req, err_req, toggle, rise, copy, reseed;
  logic [W-1:0] clamp_len, src_per, src_ph, seed;

  always_comb begin
    bad       = cfg_wr && (cfg_mod_half == '0 || cfg_sig_period < W'(2) || cfg_sig_phase >= cfg_sig_period);
    ok        = cfg_wr && !bad;
    clamp_len = (cfg_pulse_len >= cfg_sig_period) ? cfg_sig_period - W'(1) : cfg_pulse_len;
    start_req = start || start_p_q;
    stop_req  = stop || stop_p_q;
    err_req   = bad || err_p_q;
    toggle    = mod_cnt_q == ac_half_q - W'(1);
    rise      = toggle && !mod_q;
    // a pending shadow goes live either straight away in IDLE or at a RUN mod rise
    copy      = clk_en && pend_q && (state_q == S_IDLE || (state_q == S_RUN && rise));
    src_per   = copy ? sh_per_q : ac_per_q;
    src_ph    = copy ? sh_ph_q : ac_ph_q;
    seed      = (src_ph == '0) ? '0 : src_per - src_ph;
    reseed    = clk_en && ((state_q == S_IDLE && start_req) || (state_q == S_RUN && copy));
    sh_half_d = ok ? cfg_mod_half : sh_half_q;
    sh_per_d  = ok ? cfg_sig_period : sh_per_q;
    sh_ph_d   = ok ? cfg_sig_phase : sh_ph_q;
    sh_len_d  = ok ? clamp_len : sh_len_q;
    pend_d    = ok || (pend_q && !copy);
    start_p_d = !clk_en && start_req;
    stop_p_d  = !clk_en && stop_req;
    err_p_d   = !clk_en && err_req;
    ac_half_d = copy ? sh_half_q : ac_half_q;
    ac_per_d  = copy ? sh_per_q : ac_per_q;
    ac_ph_d   = copy ? sh_ph_q : ac_ph_q;
    ac_len_d  = copy ? sh_len_q : ac_len_q;
    state_d         = state_q;
    mod_d           = mod_q;
    signal_d        = signal_q;
    busy_d          = busy_q;
    exp_valid_d     = exp_valid_q;
    cfg_err_d       = cfg_err_q;
    edge_d          = edge_q;
    blank_d         = blank_q;
    mod_cnt_d       = mod_cnt_q;
    sig_cnt_d       = sig_cnt_q;
    expected_frac_d = expected_frac_q;
    if (clk_en) begin
      cfg_err_d       = err_req;
      exp_valid_d     = edge_q && state_q == S_RUN && !blank_q;
      expected_frac_d = exp_valid_d ? sig_cnt_q : expected_frac_q;
      if (state_q == S_IDLE) begin
        state_d   = start_req ? S_RUN : S_IDLE;
        mod_d     = start_req;
        edge_d    = start_req;
        mod_cnt_d = '0;
        sig_cnt_d = start_req ? seed : '0;
      end else begin
        mod_cnt_d = toggle ? '0 : mod_cnt_q + W'(1);
        mod_d     = mod_q ^ toggle;
        edge_d    = toggle;
        sig_cnt_d = reseed ? seed : (sig_cnt_q == ac_per_q - W'(1)) ? '0 : sig_cnt_q + W'(1);
        state_d   = (state_q == S_RUN && stop_req) ? S_DRAIN : state_q;
        if (state_q == S_DRAIN && rise) begin
          state_d   = S_IDLE;
          mod_d     = 1'b0;
          edge_d    = 1'b0;
          mod_cnt_d = '0;
          sig_cnt_d = '0;
        end
      end
      blank_d  = state_d != S_IDLE && (reseed ? seed != '0 : blank_q && sig_cnt_d != '0);
      signal_d = state_d != S_IDLE && !blank_d && sig_cnt_d < ac_len_d;
      busy_d   = state_d != S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      mod_q           <= 1'b0;
      signal_q        <= 1'b0;
      busy_q          <= 1'b0;
      exp_valid_q     <= 1'b0;
      cfg_err_q       <= 1'b0;
      edge_q          <= 1'b0;
      blank_q         <= 1'b0;
      pend_q          <= 1'b0;
      start_p_q       <= 1'b0;
      stop_p_q        <= 1'b0;
      err_p_q         <= 1'b0;
      mod_cnt_q       <= '0;
      sig_cnt_q       <= '0;
      expected_frac_q <= '0;
      sh_half_q       <= W'(DEF_MOD_HALF);
      sh_per_q        <= W'(DEF_SIG_PERIOD);
      sh_ph_q         <= W'(DEF_SIG_PHASE);
      sh_len_q        <= W'(DEF_PULSE_LEN);
      ac_half_q       <= W'(DEF_MOD_HALF);
      ac_per_q        <= W'(DEF_SIG_PERIOD);
      ac_ph_q         <= W'(DEF_SIG_PHASE);
      ac_len_q        <= W'(DEF_PULSE_LEN);
    end else begin
      state_q         <= state_d;
      mod_q           <= mod_d;
      signal_q        <= signal_d;
      busy_q          <= busy_d;
      exp_valid_q     <= exp_valid_d;
      cfg_err_q       <= cfg_err_d;
      edge_q          <= edge_d;
      blank_q         <= blank_d;
      pend_q          <= pend_d;
      start_p_q       <= start_p_d;
      stop_p_q        <= stop_p_d;
      err_p_q         <= err_p_d;
      mod_cnt_q       <= mod_cnt_d;
      sig_cnt_q       <= sig_cnt_d;
      expected_frac_q <= expected_frac_d;
      sh_half_q       <= sh_half_d;
      sh_per_q        <= sh_per_d;
      sh_ph_q         <= sh_ph_d;
      sh_len_q        <= sh_len_d;
      ac_half_q       <= ac_half_d;
      ac_per_q        <= ac_per_d;
      ac_ph_q         <= ac_ph_d;
      ac_len_q        <= ac_len_d;
    end
  end

  assign mod           = mod_q;
  assign signal        = signal_q;
  assign busy          = busy_q;
  assign exp_valid     = exp_valid_q;
  assign cfg_err       = cfg_err_q;
  assign expected_frac = expected_frac_q;
endmodule

// File: tb/tb_frac_stim_gen.sv
// tb_frac_stim_gen: random and directed stimulus against an elapsed-time reference model, checked through a scoreboard
module tb_frac_stim_gen;
  logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [15:0] cfg_mod_half = '0, cfg_sig_period = '0, cfg_sig_phase = '0, cfg_pulse_len = '0;
  logic        mod, signal, exp_valid, busy, cfg_err;
  logic [15:0] expected_frac;

  frac_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .stop(stop), .cfg_wr(cfg_wr),
    .cfg_mod_half(cfg_mod_half), .cfg_sig_period(cfg_sig_period), .cfg_sig_phase(cfg_sig_phase),
    .cfg_pulse_len(cfg_pulse_len), .mod(mod), .signal(signal), .expected_frac(expected_frac),
    .exp_valid(exp_valid), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic m, s, b, v, e;} wave_t;
  wave_t wave_q[$];
  int    frac_q[$];
  int    n_cmp = 0, n_bad = 0;

  // model: state 0 idle / 1 run / 2 drain; m_n = enabled cycles since the current phase base
  int m_st, m_n, m_pend, p_start, p_stop, p_err, nx_val, nx_frac;
  int a_half, a_per, a_ph, a_len, s_half, s_per, s_ph, s_len;
  bit o_mod, o_sig, o_busy, o_val, o_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_n = 0; m_pend = 0; p_start = 0; p_stop = 0; p_err = 0; nx_val = 0; nx_frac = 0;
    a_half = 100; a_per = 37; a_ph = 0; a_len = 4;
    s_half = 100; s_per = 37; s_ph = 0; s_len = 4;
    o_mod = 0; o_sig = 0; o_busy = 0; o_val = 0; o_err = 0;
  endtask

  function automatic wave_t cur();
    return '{o_mod, o_sig, o_busy, o_val, o_err};
  endfunction

  task automatic step();
    int h, p, ph, l, oh, op, oph, ol, nn;
    bit bad, ok, st, sp, er, cp;
    h = int'(cfg_mod_half); p = int'(cfg_sig_period); ph = int'(cfg_sig_phase); l = int'(cfg_pulse_len);
    bad = cfg_wr && (h == 0 || p < 2 || ph >= p);
    ok = cfg_wr && !bad;
    st = start || p_start != 0; sp = stop || p_stop != 0; er = bad || p_err != 0;
    oh = s_half; op = s_per; oph = s_ph; ol = s_len;
    if (ok) begin
      s_half = h; s_per = p; s_ph = ph; s_len = (l > p - 1) ? p - 1 : l;
    end
    if (!clk_en) begin
      p_start = st; p_stop = sp; p_err = er;
      if (ok) m_pend = 1;
      return;
    end
    p_start = 0; p_stop = 0; p_err = 0; cp = 0;
    if (m_st == 0) begin
      if (m_pend != 0) begin a_half = oh; a_per = op; a_ph = oph; a_len = ol; cp = 1; end
      if (st) begin m_st = 1; m_n = 0; end
    end else begin
      nn = m_n + 1;
      if (nn % (2 * a_half) == 0) begin
        if (m_st == 2) m_st = 0;
        else if (m_pend != 0) begin a_half = oh; a_per = op; a_ph = oph; a_len = ol; cp = 1; nn = 0; end
      end
      m_n = nn;
      if (m_st == 1 && sp) m_st = 2;
    end
    m_pend = ok ? 1 : cp ? 0 : m_pend;
    o_val = nx_val != 0;
    if (nx_val != 0) frac_q.push_back(nx_frac);
    o_err = er;
    if (m_st == 0) begin
      o_mod = 0; o_sig = 0; o_busy = 0; nx_val = 0;
    end else begin
      o_mod = ((m_n / a_half) % 2) == 0;
      o_sig = (m_n >= a_ph) && ((m_n - a_ph) % a_per < a_len);
      o_busy = 1;
      nx_val = int'(m_st == 1 && m_n % a_half == 0 && m_n >= a_ph);
      nx_frac = (m_n >= a_ph) ? (m_n - a_ph) % a_per : 0;
    end
  endtask

  task automatic cyc(input bit en, input bit st, input bit sp, input bit wr,
                     input int h, input int p, input int ph, input int l);
    @(posedge clk); #1;
    rst_n = 1'b1; clk_en = en; start = st; stop = sp; cfg_wr = wr;
    cfg_mod_half = 16'(h); cfg_sig_period = 16'(p); cfg_sig_phase = 16'(ph); cfg_pulse_len = 16'(l);
    step();
    wave_q.push_back(cur());
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0;
    if (wave_q.size() > 0) void'(wave_q.pop_back());
    frac_q.delete();
    model_reset();
    wave_q.push_back(cur());
    wave_q.push_back(cur());
  endtask

  task automatic scen(input int h, input int p, input int ph, input int l, input int n);
    cyc(1, 0, 0, 1, h, p, ph, l);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(n);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(2 * h + 5);
  endtask

  always @(negedge clk) begin
    if (wave_q.size() > 0) begin
      wave_t w;
      w = wave_q.pop_front();
      chk("mod", int'(mod), int'(w.m));
      chk("signal", int'(signal), int'(w.s));
      chk("busy", int'(busy), int'(w.b));
      chk("exp_valid", int'(exp_valid), int'(w.v));
      chk("cfg_err", int'(cfg_err), int'(w.e));
      if (exp_valid && clk_en && rst_n) begin
        if (frac_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frac at %0t: got unexpected strobe %0d want none", $time, expected_frac);
        end else chk("frac", int'(expected_frac), frac_q.pop_front());
      end
    end
  end

  initial begin
    int p;
    model_reset();
    @(posedge clk); #1;
    wave_q.push_back(cur());
    wave_q.push_back(cur());
    scen(10, 7, 3, 2, 45);
    scen(10, 7, 0, 2, 25);
    cyc(1, 0, 0, 1, 10, 0, 0, 2);
    run(2);
    scen(10, 7, 0, 9, 20);
    cyc(1, 0, 0, 1, 10, 7, 3, 2);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(!(i >= 12 && i <= 16), 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(30);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(30);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(30);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(25);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(1, 0, 0, i == 5, 10, 5, 3, 2);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(30);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(15);
    do_reset();
    run(3);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(230);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(210);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      else begin
        p = int'($urandom % 16);
        cyc($urandom % 8 != 0, $urandom % 20 == 0, $urandom % 40 == 0, $urandom % 25 == 0,
            int'($urandom % 13), p, int'($urandom % (p + 1)), int'($urandom % 20));
      end
    end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    run(40);
    repeat (3) @(posedge clk);
    chk("frac_queue_empty", frac_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
